// File: rtl/cmp_pkg.sv
// Shared definitions for the digit-serial comparator: operation codes, FSM
// states and the parameter legality check used at elaboration.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_SLT  = 3'd0,
        OP_SLTU = 3'd1,
        OP_SEQ  = 3'd2,
        OP_SNE  = 3'd3,
        OP_SGE  = 3'd4,
        OP_SGEU = 3'd5,
        OP_MIN  = 3'd6,
        OP_MAX  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The operand must split into a whole number of digits.
    function automatic bit params_legal(input int width, input int digit);
        return (digit > 32'sd0) && (width >= digit) && ((width % digit) == 32'sd0);
    endfunction

endpackage

// File: rtl/add_digit.sv
// One digit slice of the serial subtractor: a DIGIT-bit ripple adder that also
// exposes the carry into its top bit for signed overflow detection.
module add_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carry_in,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out,
    output logic             carry_into_msb
);

    logic [DIGIT:0] c_s;

    // Ripple carry chain across the digit.
    always_comb begin
        c_s    = '0;
        sum    = '0;
        c_s[0] = carry_in;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
        end
    end

    assign carry_out      = c_s[DIGIT];
    assign carry_into_msb = c_s[DIGIT-1];

endmodule

// File: rtl/compare_serial.sv
// Digit-serial compare unit: computes a - b one digit per cycle, then derives
// signed/unsigned/equality results (or MIN/MAX selection) from the final flags.
module compare_serial
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] cmp_res
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
            $error("compare_serial: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_e           state_r;
    state_e           state_s;
    op_e              op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] nb_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             eq_r;
    logic [DIGIT-1:0] sum_s;
    logic             cout_s;
    logic             cim_s;
    logic             last_s;
    logic             ovf_s;
    logic             slt_s;
    logic             ult_s;
    logic             eq_s;

    // Low digit of a plus low digit of ~b; the initial carry of 1 completes a - b.
    add_digit #(.DIGIT(DIGIT)) u_add_digit (
        .a              (a_sh_r[DIGIT-1:0]),
        .b              (nb_sh_r[DIGIT-1:0]),
        .carry_in       (carry_r),
        .sum            (sum_s),
        .carry_out      (cout_s),
        .carry_into_msb (cim_s)
    );

    assign last_s    = (cnt_r == CW'(N - 1));
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign cmp_res   = res_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Flags are only meaningful on the last digit, when sum_s holds the MSB digit.
    always_comb begin
        ovf_s = cim_s ^ cout_s;
        slt_s = sum_s[DIGIT-1] ^ ovf_s;
        ult_s = ~cout_s;
        eq_s  = eq_r & (sum_s == '0);
        res_s = '0;
        case (op_r)
            OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, ult_s};
            OP_SEQ:  res_s = {{(WIDTH-1){1'b0}}, eq_s};
            OP_SNE:  res_s = {{(WIDTH-1){1'b0}}, ~eq_s};
            OP_SGE:  res_s = {{(WIDTH-1){1'b0}}, ~slt_s};
            OP_SGEU: res_s = {{(WIDTH-1){1'b0}}, ~ult_s};
            OP_MIN:  res_s = slt_s ? a_r : b_r;
            OP_MAX:  res_s = slt_s ? b_r : a_r;
            default: res_s = '0;
        endcase
    end

    // Operand capture, digit shifting and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= OP_SLT;
            a_r     <= '0;
            b_r     <= '0;
            a_sh_r  <= '0;
            nb_sh_r <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            eq_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r    <= op_e'(op);
                        a_r     <= operand_a;
                        b_r     <= operand_b;
                        a_sh_r  <= operand_a;
                        nb_sh_r <= ~operand_b;
                        cnt_r   <= '0;
                        carry_r <= 1'b1;
                        eq_r    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_sh_r  <= a_sh_r >> DIGIT;
                    nb_sh_r <= nb_sh_r >> DIGIT;
                    carry_r <= cout_s;
                    eq_r    <= eq_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        res_r <= res_s;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_serial.sv
// Directed bench for compare_serial: vector table on the 32/8 build plus
// backpressure, reset-abort and single-digit (16/16) sequences.
module tb_compare_serial;
    import cmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] cmp_res;

    logic        in_valid2;
    logic        in_ready2;
    logic [15:0] a2;
    logic [15:0] b2;
    logic [2:0]  op2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] cmp_res2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compare_serial #(.WIDTH(32), .DIGIT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(a), .operand_b(b), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .cmp_res(cmp_res)
    );

    compare_serial #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .operand_a(a2), .operand_b(b2), .op(op2), .out_valid(out_valid2),
        .out_ready(out_ready2), .cmp_res(cmp_res2)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request on the 32-bit unit and wait (bounded) for out_valid.
    task automatic do_req(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = cmp_res;
    endtask

    task automatic finish_req(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic do_req16(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                            input logic [15:0] exp, input string name);
        int lat;
        @(negedge clk);
        in_valid2 = 1'b1; op2 = o; a2 = av; b2 = bv;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 1;
        while (!out_valid2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_res"}, {16'd0, cmp_res2}, {16'd0, exp});
        check({name, "_lat"}, 32'(lat), 32'd2);
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check({name, "_idle"}, {31'd0, in_ready2}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        bit          saw_valid;

        vecs[0]  = '{3'd0, 32'h8000_0000, 32'h0000_0001, 32'd1};
        vecs[1]  = '{3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        vecs[2]  = '{3'd1, 32'h0000_0001, 32'hFFFF_FFFF, 32'd1};
        vecs[3]  = '{3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1};
        vecs[4]  = '{3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0};
        vecs[5]  = '{3'd6, 32'hFFFF_FFFE, 32'h0000_0005, 32'hFFFF_FFFE};
        vecs[6]  = '{3'd7, 32'hFFFF_FFFE, 32'h0000_0005, 32'h0000_0005};
        vecs[7]  = '{3'd4, 32'h0000_0005, 32'h0000_0005, 32'd1};
        vecs[8]  = '{3'd5, 32'h0000_0000, 32'h0000_0001, 32'd0};
        vecs[9]  = '{3'd1, 32'h8000_0000, 32'h0000_0001, 32'd0};
        vecs[10] = '{3'd2, 32'h1234_5678, 32'h0234_5678, 32'd0};
        vecs[11] = '{3'd3, 32'h0000_0001, 32'h0001_0001, 32'd1};
        vecs[12] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'd1};
        vecs[13] = '{3'd4, 32'h0000_0000, 32'h8000_0000, 32'd1};
        vecs[14] = '{3'd6, 32'h0000_0003, 32'h0000_0007, 32'h0000_0003};
        vecs[15] = '{3'd7, 32'h0000_0003, 32'h0000_0007, 32'h0000_0007};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res", cmp_res, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
            finish_req($sformatf("vec%0d", i));
        end

        // Backpressure, with junk requests held on the input throughout.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 32'h8000_0000; b = 32'h0000_0001;
        @(posedge clk); #1;
        op = 3'd7; a = 32'h0000_1234; b = 32'h0000_5678;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd5);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp%0d_res", c), cmp_res, 32'd1);
            check($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_ready", c), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        finish_req("bp_hs");

        // Reset on the second RUN edge drops the operation.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd1; a = 32'h0000_0001; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rrun_valid", {31'd0, out_valid}, 32'd0);
        check("rrun_ready", {31'd0, in_ready}, 32'd1);
        check("rrun_res", cmp_res, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("rrun_no_output", {31'd0, saw_valid}, 32'd0);
        do_req(3'd1, 32'h0000_0001, 32'hFFFF_FFFF, res, lat);
        check("rrun_next_res", res, 32'd1);
        check("rrun_next_lat", 32'(lat), 32'd5);
        finish_req("rrun_next");

        // Reset while a result waits in DONE.
        do_req(3'd6, 32'hFFFF_FFFE, 32'h0000_0005, res, lat);
        check("rdone_pre", res, 32'hFFFF_FFFE);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rdone_valid", {31'd0, out_valid}, 32'd0);
        check("rdone_res", cmp_res, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-digit build: RUN is one edge.
        do_req16(3'd5, 16'h0000, 16'hFFFF, 16'h0000, "w16_sgeu");
        do_req16(3'd0, 16'h8000, 16'h0001, 16'h0001, "w16_slt");
        do_req16(3'd7, 16'h8000, 16'h7FFF, 16'h7FFF, "w16_max");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
